// File: rtl/mem_bus_arb_pkg.sv
// mem_bus_arb_pkg: shared types and constants for the memory bus arbiter
package mem_bus_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam logic [DATA_W-1:0] BUS_TIMEOUT_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_arbiter_pick: round-robin pick of the first requester after last_i, wrapping
// Ports: req_i request vector, last_i previous owner, grant_o one-hot pick (0 if none), idx_o pick index
module rr_arbiter_pick #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  // Lowest requester above last wins; if none, lowest at or below last.
  always_comb begin
    idx_o = '0;
    for (int j = N - 1; j >= 0; j--)
      if (req_i[j] && j <= int'(last_i)) idx_o = IW'(j);
    for (int j = N - 1; j >= 0; j--)
      if (req_i[j] && j > int'(last_i)) idx_o = IW'(j);
    grant_o = (|req_i) ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory bus among NUM_MASTERS requesters
// Master side: m_sel_i/m_addr_i/m_we_i/m_wr_mask_i/m_data_i in, m_ack_o one-hot and m_data_o broadcast out.
// Slave side: registered s_sel_o/s_addr_o/s_we_o/s_wr_mask_o/s_data_o, s_ack_i/s_data_i back.
// Status: grant_o one-hot owner, timeout_o abort pulse.
// Optional MEM_BUS_ARB_TIMEOUT_EN aborts a BUSY transaction after TIMEOUT_CYCLES cycles.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic [NUM_MASTERS-1:0]             m_sel_i,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS-1:0][MASK_W-1:0] m_wr_mask_i,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_data_i,
  output logic [DATA_W-1:0]                  m_data_o,
  output logic [NUM_MASTERS-1:0]             m_ack_o,
  output logic                               s_sel_o,
  output logic [ADDR_W-1:0]                  s_addr_o,
  output logic                               s_we_o,
  output logic [MASK_W-1:0]                  s_wr_mask_o,
  output logic [DATA_W-1:0]                  s_data_o,
  input  logic [DATA_W-1:0]                  s_data_i,
  input  logic                               s_ack_i,
  output logic [NUM_MASTERS-1:0]             grant_o,
  output logic                               timeout_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  state_t                   r_state, w_next;
  logic [IW-1:0]            r_last, r_idx, w_idx;
  logic [NUM_MASTERS-1:0]   r_grant, w_grant;
  logic                     r_sel, r_we;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_data;
  logic [MASK_W-1:0]        r_mask;
  logic                     w_busy, w_to, w_done;
  rr_arbiter_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i(m_sel_i),
    .last_i(r_last),
    .grant_o(w_grant),
    .idx_o(w_idx)
  );
  assign w_busy = r_state == BUSY;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_cnt;
  // Held at zero outside BUSY so the first BUSY cycle counts as 0.
  always_ff @(posedge clk)
    r_cnt <= (reset_i || !w_busy) ? '0 : r_cnt + 1'b1;
  // A coincident slave ack takes precedence over the abort.
  assign w_to = w_busy && !s_ack_i && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign w_to = 1'b0;
`endif
  assign w_done = w_busy && (s_ack_i || w_to);
  always_comb begin
    w_next = w_busy ? (w_done ? IDLE : BUSY) : ((|m_sel_i) ? BUSY : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_mask  <= '1;
      r_grant <= '0;
      r_idx   <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_next;
      if (!w_busy && (|m_sel_i)) begin
        r_sel   <= 1'b1;
        r_we    <= m_we_i[w_idx];
        r_addr  <= m_addr_i[w_idx];
        r_data  <= m_data_i[w_idx];
        r_mask  <= m_wr_mask_i[w_idx];
        r_grant <= w_grant;
        r_idx   <= w_idx;
      end else if (w_done) begin
        r_sel   <= 1'b0;
        r_we    <= 1'b0;
        r_grant <= '0;
        r_last  <= r_idx;
      end
    end
  end
  assign s_sel_o     = r_sel;
  assign s_we_o      = r_we;
  assign s_addr_o    = r_addr;
  assign s_data_o    = r_data;
  assign s_wr_mask_o = r_mask;
  assign grant_o     = r_grant;
  assign m_ack_o     = w_done ? r_grant : '0;
  assign m_data_o    = w_to ? BUS_TIMEOUT_DATA : s_data_i;
  assign timeout_o   = w_to;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a behavioural model
module tb_mem_bus_arbiter;
  localparam int N = 3;
  localparam int TO = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic                 reset_i;
  logic [N-1:0]         m_sel_i, m_we_i;
  logic [N-1:0][31:0]   m_addr_i, m_data_i;
  logic [N-1:0][3:0]    m_wr_mask_i;
  logic [31:0]          m_data_o, s_addr_o, s_data_o, s_data_i;
  logic [N-1:0]         m_ack_o, grant_o;
  logic                 s_sel_o, s_we_o, s_ack_i, timeout_o;
  logic [3:0]           s_wr_mask_o;
  mem_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_i(reset_i),
    .m_sel_i(m_sel_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_wr_mask_i(m_wr_mask_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o),
    .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_wr_mask_o(s_wr_mask_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );
  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  bit           mv = 1'b0;
  bit           mb, mw, found_m, c_to;
  int           mo, ml, mc, c;
  logic [31:0]  ma, md;
  logic [3:0]   mm;
  logic [N-1:0] acked = '0;
  logic [N-1:0] c_g;
  function automatic bit m_to();
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    return mb && !s_ack_i && mc == TO - 1;
`else
    return 1'b0;
`endif
  endfunction
  always @(posedge clk) begin
    acked = '0;
    if (reset_i) begin
      mv = 1'b1; mb = 1'b0; mw = 1'b0; ma = '0; md = '0; mm = 4'hF; ml = N - 1; mc = 0;
    end else if (!mb) begin
      found_m = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (ml + k) % N;
        if (!found_m && m_sel_i[c]) begin
          found_m = 1'b1; mo = c;
          ma = m_addr_i[c]; mw = m_we_i[c]; mm = m_wr_mask_i[c]; md = m_data_i[c];
        end
      end
      if (found_m) begin mb = 1'b1; mc = 0; end
    end else if (s_ack_i || m_to()) begin
      acked[mo] = 1'b1; mb = 1'b0; mw = 1'b0; ml = mo;
    end else mc++;
  end
  always @(negedge clk) if (mv) begin
    c_to = m_to();
    c_g = mb ? (N'(1) << mo) : '0;
    chk("s_sel", 32'(s_sel_o), 32'(mb));
    chk("s_addr", s_addr_o, ma);
    chk("s_we", 32'(s_we_o), 32'(mw));
    chk("s_mask", 32'(s_wr_mask_o), 32'(mm));
    chk("s_data", s_data_o, md);
    chk("grant", 32'(grant_o), 32'(c_g));
    chk("m_ack", 32'(m_ack_o), (mb && (s_ack_i || c_to)) ? 32'(c_g) : 32'd0);
    chk("m_data", m_data_o, c_to ? 32'hDEADBEEF : s_data_i);
    chk("timeout", 32'(timeout_o), 32'(c_to));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  int q[$];
  int exp_c[6] = '{0, 1, 2, 0, 1, 2};
  int gi;
  bit found;
  initial begin
    reset_i = 1'b1; m_sel_i = '0; m_we_i = '0; m_addr_i = '0; m_data_i = '0; m_wr_mask_i = '0;
    s_data_i = '0; s_ack_i = 1'b0;
    tick(); tick(); reset_i = 1'b0;
    chk("rst_mask", 32'(s_wr_mask_o), 32'hF);
    chk("rst_sel", 32'(s_sel_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    m_sel_i = 3'b001; m_addr_i[0] = 32'h100; m_wr_mask_i[0] = 4'hF;
    tick();
    chk("A_sel", 32'(s_sel_o), 32'd1);
    chk("A_addr", s_addr_o, 32'h100);
    tick(); tick();
    s_ack_i = 1'b1; s_data_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("A_ack", 32'(m_ack_o), 32'b001);
    chk("A_rdata", m_data_o, 32'hCAFEF00D);
    tick();
    s_ack_i = 1'b0; m_sel_i = '0;
    chk("A_idle", 32'(s_sel_o), 32'd0);
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    m_sel_i = 3'b011; s_ack_i = 1'b1;
    tick(); chk("B_g0", 32'(grant_o), 32'b001); m_sel_i = 3'b010;
    tick(); chk("B_gap", 32'(s_sel_o), 32'd0);
    tick(); chk("B_g1", 32'(grant_o), 32'b010); m_sel_i = '0;
    tick(); s_ack_i = 1'b0;
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    m_sel_i = '1; s_ack_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_sel_o) begin
        gi = -1;
        for (int j = 0; j < N; j++) if (grant_o[j]) gi = j;
        q.push_back(gi);
      end
    end
    chk("C_count", 32'(q.size()), 32'd6);
    for (int i = 0; i < q.size() && i < 6; i++) chk("C_order", 32'(q[i]), 32'(exp_c[i]));
    s_ack_i = 1'b0;
    m_sel_i = 3'b010; m_we_i[1] = 1'b1; m_addr_i[1] = 32'h203; m_wr_mask_i[1] = 4'b1000;
    m_data_i[1] = 32'h55000000;
    tick();
    chk("D_we", 32'(s_we_o), 32'd1);
    chk("D_addr", s_addr_o, 32'h203);
    chk("D_mask", 32'(s_wr_mask_o), 32'h8);
    chk("D_data", s_data_o, 32'h55000000);
    chk("D_grant", 32'(grant_o), 32'b010);
    m_sel_i = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("D_hold_addr", s_addr_o, 32'h203);
      chk("D_hold_we", 32'(s_we_o), 32'd1);
    end
    s_ack_i = 1'b1;
    @(negedge clk);
    chk("D_ack", 32'(m_ack_o), 32'b010);
    tick(); s_ack_i = 1'b0; m_we_i = '0;
    chk("D_we_off", 32'(s_we_o), 32'd0);
    m_sel_i = 3'b100;
    tick(); chk("E_busy", 32'(grant_o), 32'b100);
    m_sel_i = 3'b101; reset_i = 1'b1;
    tick(); reset_i = 1'b0;
    chk("E_sel", 32'(s_sel_o), 32'd0);
    chk("E_grant", 32'(grant_o), 32'd0);
    tick(); chk("E_next", 32'(grant_o), 32'b001);
    s_ack_i = 1'b1; m_sel_i = '0;
    tick(); s_ack_i = 1'b0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    m_sel_i = 3'b011;
    tick(); chk("F_grant", 32'(grant_o), 32'b010);
    found = 1'b0;
    for (int i = 1; i <= 12 && !found; i++) begin
      @(negedge clk);
      if (m_ack_o != '0) begin
        found = 1'b1;
        chk("F_cycle", 32'(i), 32'd8);
        chk("F_ack", 32'(m_ack_o), 32'b010);
        chk("F_data", m_data_o, 32'hDEADBEEF);
        chk("F_to", 32'(timeout_o), 32'd1);
      end
      tick();
    end
    chk("F_found", 32'(found), 32'd1);
    m_sel_i = 3'b001;
    tick(); chk("F_next", 32'(grant_o), 32'b001);
    s_ack_i = 1'b1; m_sel_i = '0;
    tick(); s_ack_i = 1'b0;
`endif
    for (int i = 0; i < 2000; i++) begin
      reset_i = ($urandom_range(0, 199) == 0);
      s_ack_i = ($urandom_range(0, 2) == 0);
      s_data_i = $urandom;
      for (int j = 0; j < N; j++) begin
        if (m_sel_i[j] && acked[j]) m_sel_i[j] = 1'b0;
        else if (!m_sel_i[j] && $urandom_range(0, 3) == 0) begin
          m_sel_i[j] = 1'b1;
          m_addr_i[j] = $urandom;
          m_we_i[j] = 1'($urandom_range(0, 1));
          m_wr_mask_i[j] = 4'($urandom);
          m_data_i[j] = $urandom;
        end else if (m_sel_i[j] && $urandom_range(0, 31) == 0) m_sel_i[j] = 1'b0;
      end
      tick();
    end
    reset_i = 1'b0; s_ack_i = 1'b0; m_sel_i = '0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory/peripheral bus (sel/addr/we/wr_mask/data/ack) between NUM_MASTERS requesters, e.g. processor instruction/data port, DMA, video fetch.
- Round-robin arbitration; one transaction is in flight at a time.
- Slave-side request signals are registered.
- Master-side ack and read data are combinational from the slave.
- Sits between the masters and the address decoder/RAM.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, BUSY cycles before abort; used only with MEM_BUS_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- m_sel_i  input  NUM_MASTERS  per-master request; held until that master sees its ack
- m_addr_i  input  NUM_MASTERS x 32  per-master byte address
- m_we_i  input  NUM_MASTERS  per-master write enable
- m_wr_mask_i  input  NUM_MASTERS x 4  per-master byte lanes
- m_data_i  input  NUM_MASTERS x 32  per-master write data
- m_data_o  output  32  read data, broadcast to all masters
- m_ack_o  output  NUM_MASTERS  one-hot completion strobe
- s_sel_o  output  1  slave request
- s_addr_o  output  32  slave address
- s_we_o  output  1  slave write enable
- s_wr_mask_o  output  4  slave byte lanes
- s_data_o  output  32  slave write data
- s_data_i  input  32  slave read data
- s_ack_i  input  1  slave completion, valid only while s_sel_o=1
- grant_o  output  NUM_MASTERS  one-hot current owner; 0 when idle
- timeout_o  output  1  one-cycle abort pulse

Behaviour:
- Clocking and reset: one clock, clk. reset_i is synchronous and active-high.
- Reset values:
  - state=IDLE
  - s_sel_o=0, s_we_o=0, s_addr_o=0, s_data_o=0, s_wr_mask_o=4'b1111
  - grant_o=0, timeout_o=0
  - last-grant pointer=NUM_MASTERS-1, so master 0 has first priority
- Reset mid-transaction aborts the transaction silently: no m_ack_o, slave sel drops at the reset edge.
- States: IDLE, BUSY.
- IDLE:
  - If any m_sel_i is set, pick the first requester scanning upward from (last+1) mod NUM_MASTERS, wrapping.
  - Register that master's addr/we/wr_mask/data onto the s_* outputs, set s_sel_o=1 and grant_o one-hot, go to BUSY.
  - Latency: request sampled at edge N, s_sel_o high after edge N.
- BUSY:
  - s_* outputs held stable.
  - m_ack_o[g] = s_ack_i && state==BUSY && grant_o[g], combinational.
  - m_data_o = s_data_i, combinational, always.
  - On s_ack_i: s_sel_o<=0, s_we_o<=0, grant_o<=0, last<=g, go to IDLE.
- Back-to-back transactions are separated by at least one cycle with s_sel_o=0.
- A master dropping m_sel_i during BUSY is ignored; the transaction completes and its ack is still pulsed.
- New requests arriving during BUSY wait; they are not lost as long as the masters hold sel.
- A request arriving on the same edge as s_ack_i is arbitrated in the following IDLE cycle.
- Single requester: it is served every other cycle at best (IDLE/BUSY alternation); no starvation.
- All requesters active: strict rotation 0,1,...,N-1,0.
- s_ack_i outside BUSY is ignored.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 without s_ack_i:
    - m_ack_o[g] pulses for that cycle, with m_data_o forced to 32'hDEADBEEF.
    - timeout_o pulses, s_sel_o<=0, last<=g, go to IDLE.
  - If s_ack_i and the timeout coincide, s_ack_i wins: normal completion, timeout_o=0.
- Undefined: no counter, timeout_o tied 0, BUSY waits indefinitely.

Decomposition:
- Package mem_bus_arb_pkg:
  - state enum {IDLE, BUSY}
  - BUS_TIMEOUT_DATA = 32'hDEADBEEF
  - address/data/mask width constants (32/32/4)
- Sub-module rr_arbiter_pick: combinational; takes request vector and last pointer, returns one-hot grant and index.

Test Plan:
- Single master 0 read, addr 0x100, slave acks 2 cycles after s_sel_o with 0xCAFEF00D -> s_addr_o=0x100, m_ack_o=2'b01 for 1 cycle, m_data_o=0xCAFEF00D, s_sel_o low the next cycle.
- Masters 0 and 1 request the same cycle after reset -> master 0 served first, then master 1; s_sel_o low for at least 1 cycle between them.
- 3 masters all holding sel for 6 transactions with immediate slave ack -> grant order 0,1,2,0,1,2.
- Master 1 write, addr 0x203, wr_mask 4'b1000, data 0x55000000 -> s_we_o=1, s_* outputs stable until ack, s_we_o=0 after ack.
- Assert reset_i while BUSY -> next cycle s_sel_o=0, grant_o=0, no m_ack_o; the next request goes to master 0.
- With MEM_BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> ack on BUSY cycle 8 with m_data_o=0xDEADBEEF and timeout_o=1; next requester is granted afterwards.
